apb4_reg_slave: RTL and testbench

APB4 completer (slave) terminating the APB4 bus that the AHB-to-APB bridge drives. Holds a bank of NUM_REGS 32-bit registers at BASE_ADDR, supports PSTRB byte-lane writes, a configurable number of wait states, per-register read-only protection and PSLVERROR signalling. Serves as the bridge's downstream target in the transaction-generator bench and as a reusable peripheral register block.

---
 rtl/apb4_reg_slave.sv | 129 ++++++++++++
 tb/tb_apb4_reg_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/apb4_reg_slave.sv
// APB4 completer holding a bank of 32-bit registers with byte strobes,
// configurable wait states, read-only protection and error signalling.
module apb4_reg_slave #(
  parameter int unsigned          NUM_REGS    = 16,
  parameter logic [31:0]          BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
  parameter logic [31:0]          RESET_VAL   = 32'h0
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              PADDR,
  input  logic [31:0]              PWDATA,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [3:0]               PSTRB,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERROR,
  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [7:0]               err_cnt
);

  localparam int          IDXW  = $clog2(NUM_REGS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(NUM_REGS) << 2);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [3:0]  strb_q;
  logic        latch;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [7:0]  errCnt_q, errCnt_d;

  logic [IDXW-1:0] idx;
  logic            addrErr, roHit, accErr, done;
  logic [31:0]     rdSel;

  // The base is 4-byte aligned, so the word index needs only the low address bits.
  assign idx     = addr_q[IDXW+1:2] - BASE_ADDR[IDXW+1:2];
  assign addrErr = (addr_q < BASE_ADDR) || ({1'b0, addr_q} >= LIMIT) || (addr_q[1:0] != 2'b00);

  always_comb begin
    roHit = 1'b0;
    rdSel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IDXW'(i)) begin
        roHit = RO_MASK[i];
        rdSel = regs_q[i];
      end
    end
  end

  assign accErr    = addrErr || (write_q && roHit);
  assign PREADY    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign done      = PREADY && PSEL;
  assign PSLVERROR = PREADY && accErr;
  assign PRDATA    = (PREADY && !write_q && !accErr) ? rdSel : 32'h0;
  assign err_cnt   = errCnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          latch   = 1'b1;
        end
      end
      ACCESS: begin
        // Deselecting mid-transfer abandons it without any side effect.
        if (!PSEL)                state_d = IDLE;
        else if (cnt_q != 4'd0)   cnt_d   = cnt_q - 4'd1;
        else                      state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d   = regs_q;
    errCnt_d = errCnt_q;
    if (done && accErr && (errCnt_q != 8'hFF)) errCnt_d = errCnt_q + 8'd1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (done && write_q && !accErr && (idx == IDXW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      errCnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      errCnt_q <= errCnt_d;
      regs_q   <= regs_d;
      if (latch) begin
        addr_q  <= PADDR;
        wdata_q <= PWDATA;
        write_q <= PWRITE;
        strb_q  <= PSTRB;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Scoreboard bench for apb4_reg_slave: three instances (0, 3 and 2 wait states)
// share one bus with separate selects; a monitor checks every completion.
module tb_apb4_reg_slave;

  localparam logic [31:0] BASE = 32'h4000_0000;

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        err;
  } expect_t;

  logic        clock, reset;
  logic [31:0] paddr, pwdata;
  logic        pwrite, penable;
  logic [3:0]  pstrb;
  logic        psel    [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [511:0] regOut [3];
  logic [7:0]  errCnt  [3];

  expect_t expQ[$];
  int testsRun = 0;
  int testsFailed = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb4_reg_slave #(
      .NUM_REGS(16),
      .BASE_ADDR(BASE),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
      .RO_MASK((g == 2) ? 16'h0002 : 16'h0000),
      .RESET_VAL(32'h0)
    ) dut (
      .HCLK(clock),
      .HRESET(reset),
      .PADDR(paddr),
      .PWDATA(pwdata),
      .PWRITE(pwrite),
      .PSEL(psel[g]),
      .PENABLE(penable),
      .PSTRB(pstrb),
      .PRDATA(prdata[g]),
      .PREADY(pready[g]),
      .PSLVERROR(pslverr[g]),
      .reg_out(regOut[g]),
      .err_cnt(errCnt[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts at posedge+2; bus fields are scrambled after setup so only latched values matter.
  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [31:0] expData, input logic expErr,
                               input int expCycles);
    int cycles;
    expect_t e;
    cycles  = 0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    e.dut = d; e.data = expData; e.err = expErr;
    expQ.push_back(e);
    @(posedge clock) #2;
    penable = 1'b1;
    paddr   = ~addr;
    pwdata  = ~data;
    pstrb   = ~strb;
    pwrite  = ~wr;
    do begin
      @(negedge clock);
      cycles++;
    end while (!pready[d] && cycles < 40);
    @(posedge clock) #2;
    cycles++;
    checkOutput("latency", cycles, expCycles);
    psel[d] = 1'b0;
    penable = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every completion and polices idle outputs.
  always @(negedge clock) begin
    expect_t e;
    for (int g = 0; g < 3; g++) begin
      if (pready[g] && psel[g]) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected completion", 64'(g + 1), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("completing instance", 64'(g), 64'(e.dut));
          checkOutput("PRDATA", prdata[g], e.data);
          checkOutput("PSLVERROR", pslverr[g], e.err);
        end
      end else if (!pready[g]) begin
        checkOutput("idle PRDATA/PSLVERROR", {pslverr[g], prdata[g]}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 3; g++) psel[g] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      checkOutput("reset PREADY", pready[g], 0);
      checkOutput("reset err_cnt", errCnt[g], 0);
      checkOutput("reset reg_out", regOut[g][63:0], 0);
    end
    reset = 1'b0;
    @(posedge clock) #2;

    // Zero wait states: full-word write/read, byte strobes, empty strobe, top register.
    applyStimulus(0, 1, BASE + 32'h4,  32'hDEADBEEF, 4'hF, 32'h0, 0, 2);
    applyStimulus(0, 0, BASE + 32'h4,  32'h0,        4'h0, 32'hDEADBEEF, 0, 2);
    applyStimulus(0, 1, BASE + 32'h8,  32'hAABBCCDD, 4'hF, 32'h0, 0, 2);
    applyStimulus(0, 1, BASE + 32'h8,  32'h11223344, 4'h5, 32'h0, 0, 2);
    applyStimulus(0, 0, BASE + 32'h8,  32'h0,        4'h0, 32'hAA22CC44, 0, 2);
    applyStimulus(0, 1, BASE + 32'h8,  32'hFFFFFFFF, 4'h0, 32'h0, 0, 2);
    applyStimulus(0, 0, BASE + 32'h8,  32'h0,        4'h0, 32'hAA22CC44, 0, 2);
    applyStimulus(0, 1, BASE + 32'h3C, 32'h0BADF00D, 4'hF, 32'h0, 0, 2);
    applyStimulus(0, 0, BASE + 32'h3C, 32'h0,        4'h0, 32'h0BADF00D, 0, 2);
    checkOutput("dut0 reg1", regOut[0][63:32], 32'hDEADBEEF);
    checkOutput("dut0 reg2", regOut[0][95:64], 32'hAA22CC44);
    checkOutput("dut0 reg15", regOut[0][511:480], 32'h0BADF00D);
    checkOutput("dut0 err_cnt", errCnt[0], 0);

    // Three wait states: five cycles setup to completion; address below base errors.
    applyStimulus(1, 1, BASE,          32'h12345678, 4'hF, 32'h0, 0, 5);
    applyStimulus(1, 0, BASE,          32'h0,        4'h0, 32'h12345678, 0, 5);
    applyStimulus(1, 0, 32'h3FFF_FFFC, 32'h0,        4'h0, 32'h0, 1, 5);
    checkOutput("dut1 err_cnt", errCnt[1], 1);

    // Error completions: past end, misaligned, read-only write; read of RO is fine.
    applyStimulus(2, 1, BASE + 32'h40, 32'h77777777, 4'hF, 32'h0, 1, 4);
    applyStimulus(2, 0, BASE + 32'h2,  32'h0,        4'h0, 32'h0, 1, 4);
    applyStimulus(2, 1, BASE + 32'h4,  32'hCAFEBABE, 4'hF, 32'h0, 1, 4);
    applyStimulus(2, 0, BASE + 32'h4,  32'h0,        4'h0, 32'h0, 0, 4);
    checkOutput("dut2 err_cnt", errCnt[2], 3);
    checkOutput("dut2 RO reg1", regOut[2][63:32], 32'h0);

    // Deselect part-way through a waited write: nothing written, no error counted.
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = BASE + 32'hC; pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge clock) #2;
    penable = 1'b1;
    @(posedge clock) #2;
    psel[2] = 1'b0; penable = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("abort reg3", regOut[2][127:96], 32'h0);
    checkOutput("abort err_cnt", errCnt[2], 3);
    checkOutput("abort PREADY", pready[2], 0);
    applyStimulus(2, 1, BASE + 32'hC, 32'h0000A5A5, 4'h3, 32'h0, 0, 4);
    checkOutput("post-abort reg3", regOut[2][127:96], 32'h0000A5A5);

    // Asynchronous reset in the middle of a waited write.
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = BASE; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clock) #2;
    penable = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("mid-reset PREADY", pready[1], 0);
    checkOutput("mid-reset PRDATA", prdata[1], 0);
    checkOutput("mid-reset PSLVERROR", pslverr[1], 0);
    checkOutput("mid-reset dut1 reg0", regOut[1][31:0], 32'h0);
    checkOutput("mid-reset dut0 reg1", regOut[0][63:32], 32'h0);
    checkOutput("mid-reset err_cnt", errCnt[2], 0);
    psel[1] = 1'b0; penable = 1'b0;
    @(posedge clock) #2;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    checkOutput("post-reset dut1 reg0", regOut[1][31:0], 32'h0);

    // Error counter saturates at 255.
    for (int i = 0; i < 260; i++) applyStimulus(0, 0, BASE + 32'h2, 32'h0, 4'h0, 32'h0, 1, 2);
    checkOutput("saturated err_cnt", errCnt[0], 255);

    repeat (2) @(negedge clock);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
